// File: rtl/proc_mc_pkg.sv
// Shared opcodes, R-type function codes and FSM state encoding for the
// multicycle core and its register file.
package proc_mc_pkg;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_BLTZ  = 5'b01110;
  localparam logic [4:0] OP_BGEZ  = 5'b01111;
  localparam logic [4:0] OP_RTYPE = 5'b11011;

  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_SUB  = 2'b01;
  localparam logic [1:0] FN_XOR  = 2'b10;
  localparam logic [1:0] FN_ANDN = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALTED
  } state_t;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      OP_HALT, OP_NOP, OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI,
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ, OP_RTYPE: op_legal = 1'b1;
      default:                                      op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_writes(input logic [4:0] op);
    case (op)
      OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI, OP_RTYPE: op_writes = 1'b1;
      default:                                       op_writes = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/proc_rf_param.sv
// NREG x DATA_W register file: two decode read ports, one debug read port,
// synchronous write and synchronous clear.
module proc_rf_param
  import proc_mc_pkg::*;
#(
  parameter int NREG   = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [2:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [2:0]        i_raddr_a,
  input  logic [2:0]        i_raddr_b,
  input  logic [2:0]        i_dbg_sel,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic [DATA_W-1:0] o_dbg_rdata
);

  logic [DATA_W-1:0] r_regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a   = r_regs[i_raddr_a];
  assign o_rdata_b   = r_regs[i_raddr_b];
  assign o_dbg_rdata = r_regs[i_dbg_sel];

endmodule

// File: rtl/proc_multicycle_param.sv
// Multicycle 16-bit-instruction core on a DATA_W datapath with a
// ready-handshaked instruction fetch port, sticky halt and illegal-opcode error.
//
// state    | meaning
// FETCH    | request imem[pc]; latch ir when accepted
// DECODE   | latch operands A/B; HALT or illegal opcode stops here
// EXEC     | latch ALU result and branch-taken flag
// WB       | write rt/rd, advance or branch pc
// HALTED   | sticky until rst; no fetch, no writes
module proc_multicycle_param
  import proc_mc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [15:0]       imem_rdata,
  output logic              halted,
  output logic              err,
  input  logic [2:0]        dbg_regsel,
  output logic [DATA_W-1:0] dbg_rdata
);

  state_t            r_state, w_state_nxt;
  logic              r_req, r_err, r_taken;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_a, r_b, r_res;

  logic [4:0]        w_op;
  logic [2:0]        w_rs, w_rt, w_rd, w_waddr;
  logic [1:0]        w_fn;
  logic [DATA_W-1:0] w_rf_a, w_rf_b, w_simm5, w_zimm5, w_alu;
  logic [PC_W-1:0]   w_off, w_pc_inc, w_pc_br;
  logic              w_taken, w_accept, w_we;

  assign w_op     = r_ir[15:11];
  assign w_rs     = r_ir[10:8];
  assign w_rt     = r_ir[7:5];
  assign w_rd     = r_ir[4:2];
  assign w_fn     = r_ir[1:0];
  assign w_simm5  = {{(DATA_W-5){r_ir[4]}}, r_ir[4:0]};
  assign w_zimm5  = {{(DATA_W-5){1'b0}}, r_ir[4:0]};
  assign w_off    = PC_W'($signed(r_ir[7:0]));
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_pc_br  = w_pc_inc + w_off;
  assign w_accept = r_req & imem_ready;
  assign w_we     = (r_state == S_WB) && op_writes(w_op);
  assign w_waddr  = (w_op == OP_RTYPE) ? w_rd : w_rt;

  proc_rf_param #(.NREG(NREG), .DATA_W(DATA_W)) u_rf (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (r_res),
    .i_raddr_a  (w_rs),
    .i_raddr_b  (w_rt),
    .i_dbg_sel  (dbg_regsel),
    .o_rdata_a  (w_rf_a),
    .o_rdata_b  (w_rf_b),
    .o_dbg_rdata(dbg_rdata)
  );

  always_comb begin
    w_alu   = '0;
    w_taken = 1'b0;
    case (w_op)
      OP_ADDI:  w_alu = r_a + w_simm5;
      OP_SUBI:  w_alu = w_simm5 - r_a;
      OP_XORI:  w_alu = r_a ^ w_zimm5;
      OP_ANDNI: w_alu = r_a & ~w_zimm5;
      OP_BEQZ:  w_taken = (r_a == '0);
      OP_BNEZ:  w_taken = (r_a != '0);
      OP_BLTZ:  w_taken = r_a[DATA_W-1];
      OP_BGEZ:  w_taken = ~r_a[DATA_W-1];
      OP_RTYPE: begin
        case (w_fn)
          FN_ADD:  w_alu = r_a + r_b;
          FN_SUB:  w_alu = r_b - r_a;
          FN_XOR:  w_alu = r_a ^ r_b;
          FN_ANDN: w_alu = r_a & ~r_b;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:  if (w_accept) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = (w_op == OP_HALT || !op_legal(w_op)) ? S_HALTED : S_EXEC;
      S_EXEC:   w_state_nxt = S_WB;
      S_WB:     w_state_nxt = S_FETCH;
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  // Request is registered so it is low straight out of reset and drops the cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == S_FETCH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= '0;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_taken <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:  if (w_accept) r_ir <= imem_rdata;
        S_DECODE: begin
          r_a <= w_rf_a;
          r_b <= w_rf_b;
          if (!op_legal(w_op)) r_err <= 1'b1;
        end
        S_EXEC: begin
          r_res   <= w_alu;
          r_taken <= w_taken;
        end
        S_WB:     r_pc <= r_taken ? w_pc_br : w_pc_inc;
        default: ;
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign halted    = (r_state == S_HALTED);
  assign err       = r_err;

endmodule
